spi_regfile: RTL and testbench

SPI_REGFILE -- requirements
Module: spi_regfile

---
 rtl/spi_regfile.sv | 267 ++++++++++++++++++++++++++
 tb/tb_spi_regfile.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regfile.sv
`default_nettype none
// ============================================================================
// Module   : spi_regfile
// Purpose  : SPI (mode 0) target exposing NUM_REGS registers of DATA_W bits.
//            All SPI pins are oversampled in the clk domain (clk >= 8x sclk).
//            Frame, MSB first: R/W (1 = write), 7 address bits, DATA_W data.
//            Optional readback path enabled by defining SPI_READBACK_EN.
// Ports    : clk, rst_n       - system clock, async active-low reset
//            sclk, ncs, copi  - asynchronous SPI inputs
//            cipo, cipo_oe    - SPI read data and its output enable
//            regs             - register r at [r*DATA_W +: DATA_W]
//            wr_pulse         - one-clk strobe on a committed write
//            wr_addr          - address of the last committed write
//            frame_err        - one-clk strobe on a discarded frame
// Revision : 1.0 - initial release
// ============================================================================
module spi_regfile #(
    parameter int NUM_REGS = 5,
    parameter int DATA_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       ncs,
    input  logic                       copi,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs,
    output logic                       wr_pulse,
    output logic [6:0]                 wr_addr,
    output logic                       frame_err
);

    localparam int                 c_frame_len = 8 + DATA_W;
    localparam int                 c_cnt_w     = $clog2(c_frame_len + 1);
    localparam logic [c_cnt_w-1:0] c_cmd_last  = c_cnt_w'(7);
    localparam logic [c_cnt_w-1:0] c_data_last = c_cnt_w'(c_frame_len - 1);
    localparam logic [7:0]         c_num_regs  = 8'(NUM_REGS);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_cmd  = 2'd1;
    localparam logic [1:0] c_st_data = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    // [0],[1] form the synchronizer, [2] is the delayed copy for edges
    logic [2:0]         r_sclk_sync;
    logic [2:0]         r_ncs_sync;
    logic [1:0]         r_copi_sync;
    logic [1:0]         r_flush;
    logic               r_armed;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [DATA_W-1:0]  r_shift;
    logic [c_cnt_w-1:0] r_bit_cnt;
    logic               r_ovf;
    logic               r_rw;
    logic [6:0]         r_addr;
    logic               r_wr_pulse;
    logic               r_frame_err;
    logic [6:0]         r_wr_addr;
    logic [DATA_W-1:0]  r_regs [NUM_REGS];

    logic               w_sclk_rise;
    logic               w_ncs_fall;
    logic               w_ncs_rise;
    logic               w_ncs_low;
    logic               w_copi;
    logic               w_bit;
    logic [7:0]         w_cmd;
    logic               w_addr_ok;
    logic               w_commit;
    logic               w_err;
    logic               w_enter_data;

    // ------------------------------------------------------------------
    // Input synchronizers. ncs resets high and sclk low so that reset
    // release never looks like an edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= 3'b000;
            r_ncs_sync  <= 3'b111;
            r_copi_sync <= 2'b00;
            r_flush     <= 2'b00;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], sclk};
            r_ncs_sync  <= {r_ncs_sync[1:0], ncs};
            r_copi_sync <= {r_copi_sync[0], copi};
            r_flush     <= {r_flush[0], 1'b1};
            // Frames are accepted only once ncs has been seen high with
            // real (post-reset) data in the synchronizer, so a frame that
            // started during reset is ignored until ncs returns high.
            if (r_flush[1] && r_ncs_sync[1]) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_ncs_fall  = ~r_ncs_sync[1] & r_ncs_sync[2];
    assign w_ncs_rise  = r_ncs_sync[1] & ~r_ncs_sync[2];
    assign w_ncs_low   = ~r_ncs_sync[1];
    assign w_copi      = r_copi_sync[1];
    assign w_bit       = w_sclk_rise & w_ncs_low & (r_state != c_st_idle);

    // Command byte as it stands once the current bit is shifted in
    assign w_cmd     = {r_shift[6:0], w_copi};
    assign w_addr_ok = ({1'b0, r_addr} < c_num_regs);

    // ------------------------------------------------------------------
    // Frame FSM: next state and single-cycle control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_commit     = 1'b0;
        w_err        = 1'b0;
        w_enter_data = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_ncs_fall && r_armed) begin
                    w_state_nxt = c_st_cmd;
                end
            end
            c_st_cmd: begin
                if (w_ncs_rise) begin
                    w_state_nxt = c_st_idle;
                    w_err       = 1'b1;
                end else if (w_bit && (r_bit_cnt == c_cmd_last)) begin
                    w_state_nxt  = c_st_data;
                    w_enter_data = 1'b1;
                end
            end
            c_st_data: begin
                if (w_ncs_rise) begin
                    w_state_nxt = c_st_idle;
                    w_err       = 1'b1;
                end else if (w_bit && (r_bit_cnt == c_data_last)) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                if (w_ncs_rise) begin
                    w_state_nxt = c_st_idle;
                    if (r_ovf) begin
                        w_err = 1'b1;
                    end else if (r_rw && w_addr_ok) begin
                        w_commit = 1'b1;
                    end
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_ovf       <= 1'b0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_wr_pulse  <= 1'b0;
            r_frame_err <= 1'b0;
            r_wr_addr   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_pulse  <= w_commit;
            r_frame_err <= w_err;
            if (r_state == c_st_idle) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
                r_ovf     <= 1'b0;
            end else if (w_bit) begin
                if (r_state == c_st_done) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_shift   <= {r_shift[DATA_W-2:0], w_copi};
                    r_bit_cnt <= r_bit_cnt + c_cnt_w'(1);
                end
            end
            if (w_enter_data) begin
                r_rw   <= w_cmd[7];
                r_addr <= w_cmd[6:0];
            end
            if (w_commit) begin
                r_wr_addr <= r_addr;
            end
        end
    end

    // After a full frame the shift register holds exactly the data field
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (r_addr == 7'(i)) begin
                    r_regs[i] <= r_shift;
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
            assign regs[g*DATA_W +: DATA_W] = r_regs[g];
        end
    endgenerate

    assign wr_pulse  = r_wr_pulse;
    assign frame_err = r_frame_err;
    assign wr_addr   = r_wr_addr;

`ifdef SPI_READBACK_EN
    localparam logic [c_cnt_w-1:0] c_first_shift = c_cnt_w'(9);

    logic              w_sclk_fall;
    logic [DATA_W-1:0] w_rd_data;
    logic [DATA_W-1:0] r_tx;
    logic              r_oe;

    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];

    // Out-of-range addresses read as zero
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_cmd[6:0] == 7'(i)) begin
                w_rd_data = r_regs[i];
            end
        end
    end

    // The fall right after the 8th rise must not shift: the controller
    // samples the MSB on the 9th rise. Shifting starts on the fall that
    // follows the first data-bit rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx <= '0;
            r_oe <= 1'b0;
        end else if (w_enter_data) begin
            r_tx <= w_rd_data;
            r_oe <= ~w_cmd[7];
        end else begin
            if (w_state_nxt != c_st_data) begin
                r_oe <= 1'b0;
            end
            if ((r_state == c_st_data) && w_sclk_fall && (r_bit_cnt >= c_first_shift)) begin
                r_tx <= {r_tx[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign cipo    = r_oe & r_tx[DATA_W-1];
    assign cipo_oe = r_oe;
`else
    assign cipo    = 1'b0;
    assign cipo_oe = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_regfile
// Purpose  : Self-checking bench for spi_regfile. Two instances: 5x8 bit and
//            16x16 bit. Expected write/error events are queued per instance
//            and popped by monitors whenever wr_pulse or frame_err fires.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  sclk_v;
    logic [1:0]  ncs_v;
    logic [1:0]  copi_v;

    logic        cipo1, oe1, wp1, fe1;
    logic [39:0] regs1;
    logic [6:0]  wa1;
    logic        cipo2, oe2, wp2, fe2;
    logic [255:0] regs2;
    logic [6:0]  wa2;

    always #5 clk = ~clk;

    spi_regfile #(.NUM_REGS(5), .DATA_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk_v[0]), .ncs(ncs_v[0]), .copi(copi_v[0]),
        .cipo(cipo1), .cipo_oe(oe1), .regs(regs1), .wr_pulse(wp1),
        .wr_addr(wa1), .frame_err(fe1)
    );

    spi_regfile #(.NUM_REGS(16), .DATA_W(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk_v[1]), .ncs(ncs_v[1]), .copi(copi_v[1]),
        .cipo(cipo2), .cipo_oe(oe2), .regs(regs2), .wr_pulse(wp2),
        .wr_addr(wa2), .frame_err(fe2)
    );

    typedef struct {
        bit          err;
        int          addr;
        logic [31:0] data;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    logic [31:0] m1[5];
    logic [31:0] m2[16];
    int          total = 0;
    int          bad   = 0;

    // ------------------------------------------------------------------
    // Monitors
    // ------------------------------------------------------------------
    always @(negedge clk) begin : mon1
        exp_t e;
        if (wp1 || fe1) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL mon1_unexpected: wr_pulse=%0b frame_err=%0b, required no event", wp1, fe1);
            end else begin
                e = q1.pop_front();
                if (e.err) begin
                    if (!(fe1 && !wp1)) begin
                        bad++;
                        $display("FAIL mon1_err: wr_pulse=%0b frame_err=%0b, required frame_err only", wp1, fe1);
                    end
                end else if (!(wp1 && !fe1) || wa1 != e.addr[6:0] || regs1[e.addr*8 +: 8] != e.data[7:0]) begin
                    bad++;
                    $display("FAIL mon1_write: wp=%0b fe=%0b addr=%0d reg=0x%0h, required wp=1 addr=%0d reg=0x%0h",
                             wp1, fe1, wa1, regs1[e.addr*8 +: 8], e.addr, e.data[7:0]);
                end
            end
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (wp2 || fe2) begin
            total++;
            if (q2.size() == 0) begin
                bad++;
                $display("FAIL mon2_unexpected: wr_pulse=%0b frame_err=%0b, required no event", wp2, fe2);
            end else begin
                e = q2.pop_front();
                if (e.err) begin
                    if (!(fe2 && !wp2)) begin
                        bad++;
                        $display("FAIL mon2_err: wr_pulse=%0b frame_err=%0b, required frame_err only", wp2, fe2);
                    end
                end else if (!(wp2 && !fe2) || wa2 != e.addr[6:0] || regs2[e.addr*16 +: 16] != e.data[15:0]) begin
                    bad++;
                    $display("FAIL mon2_write: wp=%0b fe=%0b addr=%0d reg=0x%0h, required wp=1 addr=%0d reg=0x%0h",
                             wp2, fe2, wa2, regs2[e.addr*16 +: 16], e.addr, e.data[15:0]);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, expv);
        end
    endtask

    task automatic check_regs(input int which);
        int n = (which != 0) ? 16 : 5;
        for (int r = 0; r < n; r++) begin
            if (which != 0) chk("regs2", 64'(regs2[r*16 +: 16]), 64'(m2[r][15:0]));
            else            chk("regs1", 64'(regs1[r*8 +: 8]),   64'(m1[r][7:0]));
        end
    endtask

    task automatic send_bit(input int which, input logic b);
        copi_v[which] = b;
        repeat (5) @(posedge clk);
        #1 sclk_v[which] = 1'b1;
        repeat (5) @(posedge clk);
        #1 sclk_v[which] = 1'b0;
    endtask

    // Read data seen on cipo just before the controller's sampling rise
    task automatic check_tx(input int k, input bit rw, input logic [31:0] rdv);
        logic exp_oe;
        logic exp_c;
`ifdef SPI_READBACK_EN
        exp_oe = !rw;
        exp_c  = !rw ? rdv[7-k] : 1'b0;
`else
        exp_oe = 1'b0;
        exp_c  = 1'b0;
`endif
        chk($sformatf("tx_bit%0d", k), {62'd0, oe1, cipo1}, {62'd0, exp_oe, exp_c});
    endtask

    // One frame: nbits clocked, expected outcome derived from length/rw/addr
    task automatic frame(input int which, input int nbits, input bit rw,
                         input int addr, input logic [31:0] data);
        int          w = (which != 0) ? 16 : 8;
        int          n = (which != 0) ? 16 : 5;
        logic [63:0] fr;
        logic [31:0] rdv;
        exp_t        e;
        fr      = '0;
        fr[63]  = rw;
        fr[62:56] = addr[6:0];
        for (int j = 0; j < w; j++) fr[55-j] = data[w-1-j];
        rdv = '0;
        if (addr < n) rdv = (which != 0) ? m2[addr] : m1[addr];
        ncs_v[which] = 1'b0;
        repeat (4) @(posedge clk);
        for (int i = 0; i < nbits; i++) begin
            copi_v[which] = fr[63-i];
            repeat (5) @(posedge clk);
            #1;
            if (which == 0 && i >= 8 && i < 8 + w) check_tx(i - 8, rw, rdv);
            sclk_v[which] = 1'b1;
            repeat (5) @(posedge clk);
            #1 sclk_v[which] = 1'b0;
        end
        repeat (5) @(posedge clk);
        e.err  = 1'b0;
        e.addr = addr;
        e.data = data;
        if (nbits != 8 + w) begin
            e.err = 1'b1;
            if (which != 0) q2.push_back(e); else q1.push_back(e);
        end else if (rw && addr < n) begin
            if (which != 0) begin
                m2[addr] = {16'd0, data[15:0]};
                q2.push_back(e);
            end else begin
                m1[addr] = {24'd0, data[7:0]};
                q1.push_back(e);
            end
        end
        #1 ncs_v[which] = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        if (which != 0) chk("q2_drained", 64'(q2.size()), 64'd0);
        else            chk("q1_drained", 64'(q1.size()), 64'd0);
        if (which == 0) chk("idle_tx", {62'd0, oe1, cipo1}, 64'd0);
        check_regs(which);
    endtask

    task automatic clear_models();
        for (int r = 0; r < 5; r++)  m1[r] = '0;
        for (int r = 0; r < 16; r++) m2[r] = '0;
        q1.delete();
        q2.delete();
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst_n  = 1'b0;
        sclk_v = 2'b00;
        ncs_v  = 2'b11;
        copi_v = 2'b00;
        clear_models();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_regs1", 64'(regs1), 64'd0);
        chk("rst_out1", {57'd0, wa1}, 64'd0);
        chk("rst_strobes1", {60'd0, wp1, fe1, oe1, cipo1}, 64'd0);
        chk("rst_regs2_any", {63'd0, |regs2}, 64'd0);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);

        // Basic write, readback, short and long frames, out-of-range write
        frame(0, 16, 1'b1, 2, 32'hA5);
        frame(0, 16, 1'b0, 2, 32'h00);
        frame(0, 12, 1'b1, 1, 32'h5A);
        frame(0, 16, 1'b1, 1, 32'h5A);
        frame(0, 17, 1'b1, 4, 32'h11);
        frame(0, 16, 1'b1, 127, 32'h22);
        frame(0, 16, 1'b0, 6, 32'h00);

        // Reset in the middle of a write frame
        ncs_v[0] = 1'b0;
        repeat (4) @(posedge clk);
        for (int i = 0; i < 10; i++) send_bit(0, (i == 0) ? 1'b1 : 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_regs1", 64'(regs1), 64'd0);
        chk("midrst_addr1", {57'd0, wa1}, 64'd0);
        chk("midrst_strobes1", {60'd0, wp1, fe1, oe1, cipo1}, 64'd0);
        clear_models();
        ncs_v[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        frame(0, 16, 1'b1, 3, 32'hC3);

        // Frame already in progress when reset is released is ignored
        #1 rst_n = 1'b0;
        clear_models();
        ncs_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        for (int i = 0; i < 16; i++) send_bit(0, (i == 0 || i == 7 || i > 12) ? 1'b1 : 1'b0);
        repeat (5) @(posedge clk);
        #1 ncs_v[0] = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("late_frame_q1", 64'(q1.size()), 64'd0);
        check_regs(0);
        frame(0, 16, 1'b1, 0, 32'h3D);

        // Wide instance
        frame(1, 24, 1'b1, 15, 32'hBEEF);
        frame(1, 24, 1'b1, 0, 32'h1234);
        frame(1, 20, 1'b1, 3, 32'hFFFF);
        frame(1, 24, 1'b0, 15, 32'h0);

        // Randomized frames on both instances
        for (int t = 0; t < 36; t++) begin
            int  sel  = $urandom_range(0, 9);
            int  len  = 16;
            int  addr = $urandom_range(0, 7);
            bit  rw   = 1'($urandom_range(0, 1));
            if (sel == 7) len = $urandom_range(1, 15);
            if (sel == 8) len = $urandom_range(17, 19);
            if (sel == 9) addr = 127;
            frame(0, len, rw, addr, $urandom);
        end
        for (int t = 0; t < 8; t++) begin
            int len = ($urandom_range(0, 3) == 0) ? $urandom_range(9, 26) : 24;
            frame(1, len, 1'($urandom_range(0, 1)), $urandom_range(0, 19), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
